debounce_sync: RTL and testbench
================================

// Module: debounce_sync
// PURPOSE
//  Input conditioner in front of the pulse generator. Takes a raw async level
//  (button, external trigger, noisy pin) into clk with a multi-stage synchronizer.
//  Debounces it: a new level is accepted only after it holds for DEBOUNCE_CYCLES
//  consecutive clocks. out_level drives the edge detector's inp_trig directly,
//  so glitches never produce spurious pulses.
// PARAMETERS
//  SYNC_STAGES      2     synchronizer flip-flop count, legal range >= 2
//  DEBOUNCE_CYCLES  1000  consecutive differing clocks required to accept a change, >= 1
//  CNT_WIDTH        16    qualify counter width; must satisfy 2**CNT_WIDTH > DEBOUNCE_CYCLES
//  INIT_LEVEL       1'b0  reset value of synchronizer stages and out_level
// PORTS
//  clk        in   1  single clock, all logic on posedge
//  rst        in   1  synchronous reset, active-high
//  inp_raw    in   1  asynchronous raw input level
//  out_level  out  1  debounced, synchronized level; feeds pulse generator inp_trig
//  out_busy   out  1  high while a candidate level change is being qualified
// BEHAVIOUR
//  Reset
//   - rst sampled on posedge clk.
//   - Sync chain, out_level <= INIT_LEVEL; counter <= 0; state <= STABLE; out_busy <= 0.
//   - Reset mid-qualify discards the count; no partial credit after release.
//  Synchronizer
//   - sync[0] <= inp_raw, sync[i] <= sync[i-1]; sync_out = sync[SYNC_STAGES-1].
//   - No other logic reads inp_raw or intermediate stages.
//  State machine (2 states)
//   - STABLE: counter = 0, out_busy = 0.
//     - sync_out != out_level and DEBOUNCE_CYCLES == 1: toggle out_level this edge.
//     - sync_out != out_level otherwise: counter <= 1, go QUALIFY.
//   - QUALIFY: out_busy = 1.
//     - sync_out == out_level: counter <= 0, go STABLE, out_level unchanged (bounce rejected).
//     - sync_out != out_level and counter == DEBOUNCE_CYCLES-1: out_level <= sync_out,
//       counter <= 0, go STABLE.
//     - Otherwise: counter <= counter + 1.
//  Timing and outputs
//   - Latency: out_level changes on the (SYNC_STAGES + DEBOUNCE_CYCLES)-th posedge after the
//     first edge that samples the new inp_raw value, if the input holds throughout.
//   - out_busy is registered. It rises on the edge where the first differing sync_out is seen.
//     It falls on the edge where out_level updates or the bounce is rejected.
//   - Counter never exceeds DEBOUNCE_CYCLES-1: no wrap, no saturation logic needed.
//   - Any single-cycle disagreement resets qualification. Counting is consecutive, not cumulative.
//   - out_level toggles at most once per DEBOUNCE_CYCLES clocks. Downstream sees clean edges.
// STRUCTURE
//  - Shared header pulse_defs.vh: state encodings STABLE=1'b0, QUALIFY=1'b1 as localparams.
//    Also CNT_WIDTH default, reused by later timing blocks.
//  - One sub-module: sync_chain (params STAGES, INIT; ports clk, rst, d, q).
//    Reused for other async inputs.
//  - Top holds state register, counter, out_level register.
// TESTING  (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INIT_LEVEL=0)
//  1. rst=1 for 3 clks, inp_raw=1 -> out_level=0, out_busy=0 every cycle while rst=1.
//  2. After reset, inp_raw 0->1 held before edge 1 -> out_busy=1 after edge 3,
//     out_level=1 after edge 6, out_busy=0 after edge 6.
//  3. inp_raw=1 for 3 clks, then 0 -> out_busy pulses high 3 cycles, out_level stays 0, no change.
//  4. Bounce 1,0,1,0,1 (1 clk each), then steady 1 -> out_level rises exactly once,
//     6 edges after steady 1 starts.
//  5. Qualifying 0->1 with counter=2, assert rst 1 clk, keep inp_raw=1 ->
//     out_level=0 after reset; rises after full 6-edge latency from release.
//  6. Chain into pulse generator, 5 steady toggles every 20 clks ->
//     exactly 3 single-cycle out_pulse (rising edges only), each 7 clks after the rising inp_raw edge.

Source files
------------

// File: rtl/debounce_sync_pkg.sv
// Shared definitions for the input conditioning path: qualifier states and
// the default qualify-counter width reused by later timing blocks.
package debounce_sync_pkg;

   typedef enum logic {
      STABLE  = 1'b0,
      QUALIFY = 1'b1
   } state_t;

   localparam int unsigned CNT_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Multi-stage synchronizer for one asynchronous level; reusable for any
// external input that must be brought into clk.
module sync_chain #(
   parameter int unsigned STAGES = 2,
   parameter logic        INIT   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= {STAGES{INIT}};
      end else begin
         sr <= {sr[STAGES-2:0], d};
      end
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes a raw asynchronous level and accepts a new value only after it
// has held for DEBOUNCE_CYCLES consecutive clocks.
module debounce_sync
   import debounce_sync_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned CNT_WIDTH       = CNT_WIDTH_DEFAULT,
   parameter logic        INIT_LEVEL      = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic inp_raw,
   output logic out_level,
   output logic out_busy
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                 sync_out;
   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
   logic                 level, level_nxt;
   logic                 busy;

   sync_chain #(
      .STAGES (SYNC_STAGES),
      .INIT   (INIT_LEVEL)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (inp_raw),
      .q   (sync_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= STABLE;
         cnt   <= '0;
         level <= INIT_LEVEL;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         level <= level_nxt;
         busy  <= (state_nxt == QUALIFY);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = level;
      case (state)
         STABLE: begin
            cnt_nxt = '0;
            if (sync_out != level) begin
               // A single-cycle qualify window needs no counting at all
               if (DEBOUNCE_CYCLES == 1) begin
                  level_nxt = sync_out;
               end else begin
                  cnt_nxt   = CNT_WIDTH'(1);
                  state_nxt = QUALIFY;
               end
            end
         end
         QUALIFY: begin
            if (sync_out == level) begin
               cnt_nxt   = '0;
               state_nxt = STABLE;
            end else if (cnt == CNT_LAST) begin
               level_nxt = sync_out;
               cnt_nxt   = '0;
               state_nxt = STABLE;
            end else begin
               cnt_nxt = cnt + CNT_WIDTH'(1);
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = STABLE;
         end
      endcase
   end

   assign out_level = level;
   assign out_busy  = busy;

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: directed scenarios plus randomized
// input against a run-length reference model of the debouncer.
module tb_debounce_sync;

   localparam int unsigned SYNC = 2;
   localparam int unsigned DEB  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic inp_raw = 1'b0;
   logic out_level, out_busy;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned cyc   = 0;

   debounce_sync #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .CNT_WIDTH       (16),
      .INIT_LEVEL      (1'b0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .inp_raw   (inp_raw),
      .out_level (out_level),
      .out_busy  (out_busy)
   );

   always #5 clk = ~clk;

   // Reference: raw input delayed SYNC edges; level flips once the delayed
   // value has disagreed with it on DEB consecutive edges.
   bit m_hist[$] = '{1'b0, 1'b0};
   int m_run = 0;
   bit m_level = 1'b0;
   bit m_busy = 1'b0;

   always @(posedge clk) begin
      bit seen;
      cyc++;
      if (rst) begin
         m_hist = {};
         for (int i = 0; i < int'(SYNC); i++) m_hist.push_back(1'b0);
         m_run = 0;
         m_level = 1'b0;
      end else begin
         seen = m_hist.pop_front();
         m_hist.push_back(inp_raw);
         if (seen != m_level) begin
            m_run++;
            if (m_run == int'(DEB)) begin
               m_level = seen;
               m_run = 0;
            end
         end else begin
            m_run = 0;
         end
      end
      m_busy = (m_run > 0);
   end

   // Stand-in for the downstream rising-edge pulse generator
   logic lvl_d = 1'b0;
   logic out_pulse = 1'b0;
   always @(posedge clk) begin
      lvl_d     <= out_level;
      out_pulse <= out_level & ~lvl_d;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle_low();
      rst = 1'b1; inp_raw = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; inp_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (out_level !== 1'b0 || out_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset cyc%0d: level=%b busy=%b, want level=0 busy=0", i, out_level, out_busy);
         end
      end
   endtask

   task automatic test_latency();
      settle_low();
      inp_raw = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         n_cmp++;
         if (out_busy !== ((e >= 3 && e <= 5) ? 1'b1 : 1'b0) ||
             out_level !== ((e >= 6) ? 1'b1 : 1'b0)) begin
            n_err++;
            $display("FAIL latency edge%0d: level=%b busy=%b, want level=%b busy=%b",
                     e, out_level, out_busy, (e >= 6), (e >= 3 && e <= 5));
         end
      end
   endtask

   task automatic test_short_pulse();
      settle_low();
      for (int e = 1; e <= 10; e++) begin
         inp_raw = (e <= 3) ? 1'b1 : 1'b0;
         tick();
         n_cmp++;
         if (out_busy !== ((e >= 3 && e <= 5) ? 1'b1 : 1'b0) || out_level !== 1'b0) begin
            n_err++;
            $display("FAIL short_pulse edge%0d: level=%b busy=%b, want level=0 busy=%b",
                     e, out_level, out_busy, (e >= 3 && e <= 5));
         end
      end
   endtask

   task automatic test_bounce();
      bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      int rises = 0;
      logic prev;
      settle_low();
      prev = out_level;
      for (int e = 1; e <= 16; e++) begin
         inp_raw = (e <= 5) ? pat[e-1] : 1'b1;
         tick();
         if (out_level && !prev) rises++;
         prev = out_level;
         n_cmp++;
         if (out_level !== ((e >= 10) ? 1'b1 : 1'b0)) begin
            n_err++;
            $display("FAIL bounce edge%0d: level=%b, want %b", e, out_level, (e >= 10));
         end
      end
      n_cmp++;
      if (rises != 1) begin
         n_err++;
         $display("FAIL bounce_rises: got %0d, want 1", rises);
      end
   endtask

   task automatic test_reset_mid();
      settle_low();
      inp_raw = 1'b1;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      n_cmp++;
      if (out_level !== 1'b0 || out_busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid: level=%b busy=%b, want level=0 busy=0", out_level, out_busy);
      end
      rst = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         n_cmp++;
         if (out_level !== ((e >= 6) ? 1'b1 : 1'b0)) begin
            n_err++;
            $display("FAIL reset_mid_release edge%0d: level=%b, want %b", e, out_level, (e >= 6));
         end
      end
   endtask

   task automatic test_pulse_chain();
      int unsigned rise_at[$];
      int unsigned pulse_at[$];
      settle_low();
      for (int t = 0; t < 5; t++) begin
         inp_raw = ~inp_raw;
         if (inp_raw) rise_at.push_back(cyc);
         for (int k = 0; k < 20; k++) begin
            tick();
            if (out_pulse) pulse_at.push_back(cyc);
         end
      end
      n_cmp++;
      if (pulse_at.size() != 3) begin
         n_err++;
         $display("FAIL pulse_count: got %0d, want 3", pulse_at.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (pulse_at[i] - rise_at[i] != 7) begin
               n_err++;
               $display("FAIL pulse_delay%0d: got %0d, want 7", i, pulse_at[i] - rise_at[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      int unsigned last_toggle = 0;
      logic prev;
      settle_low();
      prev = out_level;
      for (int n = 0; n < 150; n++) begin
         int unsigned hold = $urandom_range(1, 7);
         inp_raw = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 39) == 0);
         for (int k = 0; k < int'(hold); k++) begin
            tick();
            rst = 1'b0;
            n_cmp++;
            if (out_level !== m_level || out_busy !== m_busy) begin
               n_err++;
               $display("FAIL random cyc%0d: level=%b busy=%b, want level=%b busy=%b",
                        cyc, out_level, out_busy, m_level, m_busy);
            end
            if (out_level !== prev && !rst) begin
               n_cmp++;
               if (last_toggle != 0 && cyc - last_toggle < DEB) begin
                  n_err++;
                  $display("FAIL toggle_spacing cyc%0d: gap %0d, want >= %0d", cyc, cyc - last_toggle, DEB);
               end
               last_toggle = cyc;
            end
            prev = out_level;
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_short_pulse();
      test_bounce();
      test_reset_mid();
      test_pulse_chain();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
